// File: rtl/memoria_sincrona_param_pkg.sv
// Shared FSM state type and boot image for memoria_sincrona_param.
// The boot image is only consumed when MEMORIA_PRECARGA_EN is defined.
package memoria_pkg;

   typedef enum logic [1:0] {
      LIMPIANDO   = 2'd0,
      PRECARGANDO = 2'd1,
      LISTO       = 2'd2
   } estado_t;

   // LoadInmediato 23 into R0
   localparam int LONG_ARRANQUE = 2;
   localparam logic [15:0] IMAGEN_ARRANQUE [LONG_ARRANQUE] = '{16'h4000, 16'h0017};

   function automatic logic [15:0] imagenPalabra(input int idx);
      logic [15:0] palabra;
      palabra = 16'h0000;
      for (int i = 0; i < LONG_ARRANQUE; i++) begin
         if (idx == i) palabra = IMAGEN_ARRANQUE[i];
      end
      return palabra;
   endfunction

endpackage

// File: rtl/memoria_sincrona_param_if.sv
// Request/response bus of memoria_sincrona_param; the requester owns the master side.
interface memoria_sincrona_param_if #(
   parameter int ANCHO     = 16,
   parameter int ANCHO_DIR = 4
);
   logic                 Solicitud;
   logic                 Escribir;
   logic [ANCHO_DIR-1:0] Direccion;
   logic [ANCHO-1:0]     Entrada;
   logic [ANCHO-1:0]     Salida;
   logic                 SalidaValida;
   logic                 Listo;
   logic                 Error;

   modport master (
      output Solicitud, Escribir, Direccion, Entrada,
      input  Salida, SalidaValida, Listo, Error
   );

   modport slave (
      input  Solicitud, Escribir, Direccion, Entrada,
      output Salida, SalidaValida, Listo, Error
   );
endinterface

// File: rtl/memoria_sincrona_param_arreglo.sv
// Plain storage array: one synchronous write port, one registered read port.
// Only the read register is reset; word contents are cleared by the top-level FSM.
module memoria_arreglo #(
   parameter int ANCHO       = 16,
   parameter int PROFUNDIDAD = 16,
   parameter int ANCHO_DIR   = 4
) (
   input  logic                 Reloj,
   input  logic                 Reiniciar_n,
   input  logic                 escrituraEn_i,
   input  logic [ANCHO_DIR-1:0] dirEscritura_i,
   input  logic [ANCHO-1:0]     datoEscritura_i,
   input  logic                 lecturaEn_i,
   input  logic [ANCHO_DIR-1:0] dirLectura_i,
   output logic [ANCHO-1:0]     datoLectura_o
);

   logic [ANCHO-1:0] palabras [PROFUNDIDAD];
   logic [ANCHO-1:0] datoLectura_q;

   always_ff @(posedge Reloj) begin
      if (escrituraEn_i) palabras[dirEscritura_i] <= datoEscritura_i;
   end

   // Holds the last read word until the next enabled read
   always_ff @(posedge Reloj or negedge Reiniciar_n) begin
      if (!Reiniciar_n)     datoLectura_q <= '0;
      else if (lecturaEn_i) datoLectura_q <= palabras[dirLectura_i];
   end

   assign datoLectura_o = datoLectura_q;

endmodule

// File: rtl/memoria_sincrona_param.sv
// Parametrised single-port synchronous memory with self-clearing init and range check.
// Define MEMORIA_PRECARGA_EN to load the boot image after clearing.
module memoria_sincrona_param
   import memoria_pkg::*;
#(
   parameter  int ANCHO       = 16,
   parameter  int PROFUNDIDAD = 16,
   localparam int ANCHO_DIR   = $clog2(PROFUNDIDAD)
) (
   input logic                      Reloj,
   input logic                      Reiniciar_n,
   memoria_sincrona_param_if.slave  bus
);

`ifdef MEMORIA_PRECARGA_EN
   localparam int ULTIMA_PRECARGA =
      ((LONG_ARRANQUE < PROFUNDIDAD) ? LONG_ARRANQUE : PROFUNDIDAD) - 1;
`endif

   estado_t              estado_q, estado_d;
   logic [ANCHO_DIR-1:0] contador_q, contador_d;
   logic                 salidaValida_q, salidaValida_d;
   logic                 error_q, error_d;
   logic                 aceptado, enRango;
   logic                 escrituraEn, lecturaEn;
   logic [ANCHO_DIR-1:0] dirEscritura;
   logic [ANCHO-1:0]     datoEscritura;

   assign enRango = int'(bus.Direccion) < PROFUNDIDAD;

   always_ff @(posedge Reloj or negedge Reiniciar_n) begin
      if (!Reiniciar_n) begin
         estado_q   <= LIMPIANDO;
         contador_q <= '0;
      end else begin
         estado_q   <= estado_d;
         contador_q <= contador_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      contador_d = contador_q;
      case (estado_q)
         LIMPIANDO: begin
            if (contador_q == ANCHO_DIR'(PROFUNDIDAD - 1)) begin
               contador_d = '0;
`ifdef MEMORIA_PRECARGA_EN
               estado_d   = PRECARGANDO;
`else
               estado_d   = LISTO;
`endif
            end else begin
               contador_d = contador_q + 1'b1;
            end
         end
`ifdef MEMORIA_PRECARGA_EN
         PRECARGANDO: begin
            if (contador_q == ANCHO_DIR'(ULTIMA_PRECARGA)) begin
               contador_d = '0;
               estado_d   = LISTO;
            end else begin
               contador_d = contador_q + 1'b1;
            end
         end
`endif
         LISTO:   estado_d = LISTO;
         default: estado_d = LIMPIANDO;
      endcase
   end

   // Init phases own the write port; requests are only honoured once LISTO
   always_comb begin
      aceptado       = (estado_q == LISTO) && bus.Solicitud;
      escrituraEn    = 1'b0;
      dirEscritura   = contador_q;
      datoEscritura  = '0;
      lecturaEn      = aceptado && enRango && !bus.Escribir;
      salidaValida_d = aceptado && enRango && !bus.Escribir;
      error_d        = aceptado && !enRango;
      case (estado_q)
         LIMPIANDO: escrituraEn = 1'b1;
`ifdef MEMORIA_PRECARGA_EN
         PRECARGANDO: begin
            escrituraEn   = 1'b1;
            datoEscritura = ANCHO'(imagenPalabra(int'(contador_q)));
         end
`endif
         LISTO: begin
            escrituraEn   = aceptado && enRango && bus.Escribir;
            dirEscritura  = bus.Direccion;
            datoEscritura = bus.Entrada;
         end
         default: escrituraEn = 1'b0;
      endcase
   end

   always_ff @(posedge Reloj or negedge Reiniciar_n) begin
      if (!Reiniciar_n) begin
         salidaValida_q <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         salidaValida_q <= salidaValida_d;
         error_q        <= error_d;
      end
   end

   memoria_arreglo #(
      .ANCHO       (ANCHO),
      .PROFUNDIDAD (PROFUNDIDAD),
      .ANCHO_DIR   (ANCHO_DIR)
   ) u_arreglo (
      .Reloj           (Reloj),
      .Reiniciar_n     (Reiniciar_n),
      .escrituraEn_i   (escrituraEn),
      .dirEscritura_i  (dirEscritura),
      .datoEscritura_i (datoEscritura),
      .lecturaEn_i     (lecturaEn),
      .dirLectura_i    (bus.Direccion),
      .datoLectura_o   (bus.Salida)
   );

   assign bus.SalidaValida = salidaValida_q;
   assign bus.Error        = error_q;
   assign bus.Listo        = (estado_q == LISTO);

endmodule

// File: tb/tb_memoria_sincrona_param.sv
// Directed bench for memoria_sincrona_param: a 16-word and a 12-word instance share clock and reset.
// Expected init length and boot words follow MEMORIA_PRECARGA_EN.
module tb_memoria_sincrona_param;

`ifdef MEMORIA_PRECARGA_EN
   localparam int          EXTRA = 2;
   localparam logic [15:0] PAL0  = 16'h4000;
   localparam logic [15:0] PAL1  = 16'h0017;
`else
   localparam int          EXTRA = 0;
   localparam logic [15:0] PAL0  = 16'h0000;
   localparam logic [15:0] PAL1  = 16'h0000;
`endif

   logic Reloj = 1'b0;
   logic Reiniciar_n;
   int   checkCount = 0;
   int   passCount  = 0;

   memoria_sincrona_param_if #(.ANCHO(16), .ANCHO_DIR(4)) bus16 ();
   memoria_sincrona_param_if #(.ANCHO(16), .ANCHO_DIR(4)) bus12 ();

   memoria_sincrona_param #(.ANCHO(16), .PROFUNDIDAD(16)) dut16 (
      .Reloj       (Reloj),
      .Reiniciar_n (Reiniciar_n),
      .bus         (bus16.slave)
   );

   memoria_sincrona_param #(.ANCHO(16), .PROFUNDIDAD(12)) dut12 (
      .Reloj       (Reloj),
      .Reiniciar_n (Reiniciar_n),
      .bus         (bus12.slave)
   );

   always #5 Reloj = ~Reloj;

   task automatic tick();
      @(posedge Reloj);
      #1;
   endtask

   // Releases reset and counts edges until each Listo rises, dropping held requests then
   task automatic waitInit(output int ciclos16, output int ciclos12, output int pulsos);
      ciclos16 = 0;
      ciclos12 = 0;
      pulsos   = 0;
      Reiniciar_n = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (bus16.SalidaValida !== 1'b0 || bus16.Error !== 1'b0 ||
             bus12.SalidaValida !== 1'b0 || bus12.Error !== 1'b0) pulsos++;
         if (ciclos16 == 0 && bus16.Listo === 1'b1) begin
            ciclos16 = c;
            bus16.Solicitud = 1'b0;
         end
         if (ciclos12 == 0 && bus12.Listo === 1'b1) begin
            ciclos12 = c;
            bus12.Solicitud = 1'b0;
         end
         if (ciclos16 != 0 && ciclos12 != 0) break;
      end
   endtask

   task automatic test_reset();
      int c16, c12, p;
      Reiniciar_n = 1'b0;
      bus16.Solicitud = 1'b1; bus16.Escribir = 1'b1; bus16.Direccion = 4'd0;  bus16.Entrada = 16'hFFFF;
      bus12.Solicitud = 1'b1; bus12.Escribir = 1'b0; bus12.Direccion = 4'd13; bus12.Entrada = 16'h0000;
      tick();
      tick();
      checkCount++;
      if ({bus16.Listo, bus16.SalidaValida, bus16.Error, bus16.Salida} !== 19'h0)
         $display("[TB] FAIL reset16: got %h expected 0", {bus16.Listo, bus16.SalidaValida, bus16.Error, bus16.Salida});
      else passCount++;
      checkCount++;
      if ({bus12.Listo, bus12.SalidaValida, bus12.Error, bus12.Salida} !== 19'h0)
         $display("[TB] FAIL reset12: got %h expected 0", {bus12.Listo, bus12.SalidaValida, bus12.Error, bus12.Salida});
      else passCount++;
      waitInit(c16, c12, p);
      checkCount++;
      if (c16 != 16 + EXTRA) $display("[TB] FAIL init16_cycles: got %0d expected %0d", c16, 16 + EXTRA);
      else passCount++;
      checkCount++;
      if (c12 != 12 + EXTRA) $display("[TB] FAIL init12_cycles: got %0d expected %0d", c12, 12 + EXTRA);
      else passCount++;
      checkCount++;
      if (p != 0) $display("[TB] FAIL init_pulses: got %0d expected 0", p);
      else passCount++;
   endtask

   task automatic test_preload_contents();
      logic [15:0] esperado [3];
      esperado[0] = PAL0;
      esperado[1] = PAL1;
      esperado[2] = 16'h0000;
      bus16.Solicitud = 1'b1;
      bus16.Escribir  = 1'b0;
      for (int a = 0; a < 3; a++) begin
         bus16.Direccion = 4'(a);
         tick();
         checkCount++;
         if (bus16.SalidaValida !== 1'b1 || bus16.Salida !== esperado[a])
            $display("[TB] FAIL boot_word%0d: got v=%b %h expected v=1 %h", a, bus16.SalidaValida, bus16.Salida, esperado[a]);
         else passCount++;
      end
      bus16.Solicitud = 1'b0;
      tick();
      checkCount++;
      if (bus16.SalidaValida !== 1'b0 || bus16.Salida !== 16'h0000)
         $display("[TB] FAIL boot_hold: got v=%b %h expected v=0 0000", bus16.SalidaValida, bus16.Salida);
      else passCount++;
   endtask

   task automatic test_write_read();
      bus16.Solicitud = 1'b1; bus16.Escribir = 1'b1; bus16.Direccion = 4'd5; bus16.Entrada = 16'hBEEF;
      tick();
      checkCount++;
      if (bus16.SalidaValida !== 1'b0 || bus16.Error !== 1'b0)
         $display("[TB] FAIL write_no_pulse: got v=%b e=%b expected 0 0", bus16.SalidaValida, bus16.Error);
      else passCount++;
      bus16.Escribir = 1'b0;
      tick();
      checkCount++;
      if (bus16.SalidaValida !== 1'b1 || bus16.Salida !== 16'hBEEF)
         $display("[TB] FAIL read_after_write: got v=%b %h expected v=1 beef", bus16.SalidaValida, bus16.Salida);
      else passCount++;
      bus16.Solicitud = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      bus16.Solicitud = 1'b1; bus16.Escribir = 1'b0; bus16.Direccion = 4'd5;
      tick();
      checkCount++;
      if (bus16.SalidaValida !== 1'b1 || bus16.Salida !== 16'hBEEF)
         $display("[TB] FAIL b2b_first: got v=%b %h expected v=1 beef", bus16.SalidaValida, bus16.Salida);
      else passCount++;
      bus16.Direccion = 4'd0;
      tick();
      checkCount++;
      if (bus16.SalidaValida !== 1'b1 || bus16.Salida !== PAL0)
         $display("[TB] FAIL b2b_second: got v=%b %h expected v=1 %h", bus16.SalidaValida, bus16.Salida, PAL0);
      else passCount++;
      bus16.Solicitud = 1'b0;
      tick();
      checkCount++;
      if (bus16.SalidaValida !== 1'b0 || bus16.Salida !== PAL0)
         $display("[TB] FAIL b2b_hold: got v=%b %h expected v=0 %h", bus16.SalidaValida, bus16.Salida, PAL0);
      else passCount++;
   endtask

   task automatic test_error();
      bus12.Solicitud = 1'b1; bus12.Escribir = 1'b1; bus12.Direccion = 4'd3; bus12.Entrada = 16'h1234;
      tick();
      bus12.Escribir = 1'b0;
      tick();
      checkCount++;
      if (bus12.SalidaValida !== 1'b1 || bus12.Salida !== 16'h1234 || bus12.Error !== 1'b0)
         $display("[TB] FAIL err_setup: got v=%b e=%b %h expected v=1 e=0 1234", bus12.SalidaValida, bus12.Error, bus12.Salida);
      else passCount++;
      bus12.Direccion = 4'd13;
      tick();
      checkCount++;
      if (bus12.Error !== 1'b1 || bus12.SalidaValida !== 1'b0 || bus12.Salida !== 16'h1234)
         $display("[TB] FAIL err_read13: got e=%b v=%b %h expected e=1 v=0 1234", bus12.Error, bus12.SalidaValida, bus12.Salida);
      else passCount++;
      bus12.Escribir = 1'b1; bus12.Entrada = 16'hAAAA;
      tick();
      checkCount++;
      if (bus12.Error !== 1'b1 || bus12.SalidaValida !== 1'b0 || bus12.Salida !== 16'h1234)
         $display("[TB] FAIL err_write13: got e=%b v=%b %h expected e=1 v=0 1234", bus12.Error, bus12.SalidaValida, bus12.Salida);
      else passCount++;
      bus12.Solicitud = 1'b0;
      tick();
      checkCount++;
      if (bus12.Error !== 1'b0) $display("[TB] FAIL err_width: got e=%b expected 0", bus12.Error);
      else passCount++;
      bus12.Solicitud = 1'b1; bus12.Escribir = 1'b0;
      bus12.Direccion = 4'd1;
      tick();
      checkCount++;
      if (bus12.SalidaValida !== 1'b1 || bus12.Salida !== PAL1)
         $display("[TB] FAIL err_alias1: got v=%b %h expected v=1 %h", bus12.SalidaValida, bus12.Salida, PAL1);
      else passCount++;
      bus12.Direccion = 4'd5;
      tick();
      checkCount++;
      if (bus12.SalidaValida !== 1'b1 || bus12.Salida !== 16'h0000)
         $display("[TB] FAIL err_alias5: got v=%b %h expected v=1 0000", bus12.SalidaValida, bus12.Salida);
      else passCount++;
      bus12.Solicitud = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_operation();
      int c16, c12, p;
      bus16.Solicitud = 1'b1; bus16.Escribir = 1'b0; bus16.Direccion = 4'd5;
      tick();
      bus16.Solicitud = 1'b0;
      #2;
      Reiniciar_n = 1'b0;
      #1;
      checkCount++;
      if ({bus16.Listo, bus16.SalidaValida, bus16.Error, bus16.Salida} !== 19'h0)
         $display("[TB] FAIL async_reset: got %h expected 0", {bus16.Listo, bus16.SalidaValida, bus16.Error, bus16.Salida});
      else passCount++;
      tick();
      waitInit(c16, c12, p);
      checkCount++;
      if (c16 != 16 + EXTRA) $display("[TB] FAIL reinit16_cycles: got %0d expected %0d", c16, 16 + EXTRA);
      else passCount++;
      bus16.Solicitud = 1'b1; bus16.Escribir = 1'b0; bus16.Direccion = 4'd5;
      tick();
      checkCount++;
      if (bus16.SalidaValida !== 1'b1 || bus16.Salida !== 16'h0000)
         $display("[TB] FAIL reinit_word5: got v=%b %h expected v=1 0000", bus16.SalidaValida, bus16.Salida);
      else passCount++;
      bus16.Solicitud = 1'b0;
      tick();
   endtask

   initial begin
      bus16.Solicitud = 1'b0; bus16.Escribir = 1'b0; bus16.Direccion = '0; bus16.Entrada = '0;
      bus12.Solicitud = 1'b0; bus12.Escribir = 1'b0; bus12.Direccion = '0; bus12.Entrada = '0;
      Reiniciar_n = 1'b0;
      test_reset();
      test_preload_contents();
      test_write_read();
      test_back_to_back();
      test_error();
      test_reset_mid_operation();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no completion expected finish before 200000");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/memoria_sincrona_param.md
# memoria_sincrona_param

Parametrised single-port synchronous memory for the CISC UD datapath, successor of the fixed 16x16 store. After reset it clears itself sequentially and optionally preloads a boot image, then serves one read or write request per clock over a request/valid handshake. Registered read data replaces the old tri-stated output; out-of-range addresses are flagged, not aliased.

## Interface
- ANCHO, 16: data word width in bits (>= 16).
- PROFUNDIDAD, 16: number of words (>= 2; need not be a power of two).
- ANCHO_DIR, $clog2(PROFUNDIDAD): address width (derived, not overridden).

- Reloj  in  1  single clock; all state changes on rising edge.
- Reiniciar_n  in  1  asynchronous active-low reset.
- Solicitud  in  1  request strobe; sampled only when Listo=1.
- Escribir  in  1  1 = write, 0 = read; qualified by Solicitud.
- Direccion  in  ANCHO_DIR  word address.
- Entrada  in  ANCHO  write data.
- Salida  out  ANCHO  registered read data.
- SalidaValida  out  1  one-cycle pulse: Salida carries fresh read data.
- Listo  out  1  1 = idle and accepting requests.
- Error  out  1  one-cycle pulse: accepted request had Direccion >= PROFUNDIDAD.

## Operation
- Reset values: Salida=0, SalidaValida=0, Listo=0, Error=0, FSM=LIMPIANDO, init counter=0.
- FSM states: LIMPIANDO, PRECARGANDO, LISTO.
- LIMPIANDO: writes 0 to word[counter], counter+1 each cycle; after word PROFUNDIDAD-1 -> PRECARGANDO (macro on) or LISTO (macro off); counter reset to 0.
- PRECARGANDO: writes IMAGEN_ARRANQUE[counter] to word[counter], one per cycle, for LONG_ARRANQUE words; then -> LISTO. Image words beyond PROFUNDIDAD are skipped silently.
- LISTO: Listo=1. Solicitud=1 accepted every cycle (throughput 1).
  - Write, in range: word[Direccion] <= Entrada at that edge; no SalidaValida.
  - Read, in range: Salida <= word[Direccion], SalidaValida=1 next cycle.
  - Any request with Direccion >= PROFUNDIDAD: no memory change, Salida unchanged, Error=1 next cycle, SalidaValida=0.
- Salida holds last read value until next successful read; never high-impedance.
- Requests while Listo=0 are ignored (no side effects, no pulses).
- Read of an address written in the previous cycle returns the new data.
- Reset asserted mid-init or mid-operation: immediate return to reset values; init restarts from word 0 on release.

## Timing
- Init duration: PROFUNDIDAD cycles (+ min(LONG_ARRANQUE, PROFUNDIDAD) with preload) after first edge following reset release; Listo rises on the following edge.
- Read latency 1 cycle: request at edge N -> Salida/SalidaValida valid after edge N+1, SalidaValida low after N+2 unless another read.
- Error latency 1 cycle, width 1 cycle per offending request.
- Reset path asynchronous on assertion; release is synchronised externally.

## Configuration
- MEMORIA_PRECARGA_EN defined: PRECARGANDO state compiled in; boot image (LoadInmediato 23 into R0: 16'h4000, 16'h0017 at words 0,1) loaded after clearing.
- Undefined: PRECARGANDO absent; memory all zeros when Listo rises; init takes exactly PROFUNDIDAD cycles.

## Structure
- Package memoria_pkg: FSM state enum, LONG_ARRANQUE, IMAGEN_ARRANQUE constant array (zero-extended to ANCHO).
- Sub-module memoria_arreglo: plain storage array, one synchronous write port, one synchronous read port; no reset on array contents. Top holds FSM, counter, range check, output registers.

## Test plan
- Reset release, PROFUNDIDAD=16, macro on -> Listo rises after 18 cycles; reads of 0,1,2 return 16'h4000, 16'h0017, 16'h0000.
- Macro off -> Listo after 16 cycles; read of word 0 returns 0.
- Write 16'hBEEF to 5, read 5 next cycle -> SalidaValida pulse, Salida=16'hBEEF; back-to-back reads 5,0 -> two consecutive valid pulses.
- PROFUNDIDAD=12, read/write address 13 -> Error pulse one cycle, no SalidaValida, memory and Salida unchanged.
- Solicitud held high during init -> no writes occur, no pulses; contents match cleared/preloaded image.
- Reset asserted mid-LISTO after writes -> outputs zero immediately; after re-init word 5 reads 0.
